// File: rtl/hwpe_instr_seq.sv
// hwpe_instr_seq
// ----------------------------------------------------------------------------
// Generates the full custom-instruction stream for one convolution layer of
// the HWPE accelerator from a configuration latched at start:
//   RST -> WCFG -> 4x WFAD -> ROWS*PES x WACC (optional) -> MATRIX ->
//   per tile (K outer, W, H inner): [ROWS x RELU] + ROWS*PES x RACC -> DONE
//
// Each beat is {cmd_instr, cmd_rs1, cmd_rs2}. The instruction word layout is
// {funct7, rs2, rs1, xd, xs1, xs2, rd, opcode} with the opcode fixed at 7'h0B.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request, sampled only while idle
//   cfg0_i, cfg1_i  layer config words (WCFG data)
//   base_addr_i     8 x 32-bit feature base addresses (entry n at [32n+:32])
//   k/w/h_count_i   tile loop counts; any zero skips the tile loop
//   w/h_stride_i    matrix strides
//   skip_clr_i      1 = omit the accumulator-clear (WACC) phase
//   cmd_*           command beat, valid/ready
//   busy            sequence in progress (high exactly while cmd_valid is)
//   done            one-cycle completion pulse
//
// Build option: define HWPE_SEQ_RELU_EN to compile in the RELU phase, which
// emits ROWS relu beats ahead of each tile's RACC beats.
//
// Handshake: a beat is transferred on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_valid never drops without a transfer (except
// on rst) and the payload is held stable while cmd_valid is high and
// cmd_ready is low. Payload and cmd_valid are registers; cmd_ready only
// selects whether the precomputed next beat is loaded.
// ----------------------------------------------------------------------------
module hwpe_instr_seq #(
  parameter int ROWS  = 8,
  parameter int PES   = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg0_i,
  input  logic [31:0]      cfg1_i,
  input  logic [255:0]     base_addr_i,
  input  logic [CNT_W-1:0] k_count_i,
  input  logic [CNT_W-1:0] w_count_i,
  input  logic [CNT_W-1:0] h_count_i,
  input  logic [15:0]      w_stride_i,
  input  logic [15:0]      h_stride_i,
  input  logic             skip_clr_i,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [31:0]      cmd_instr,
  output logic [31:0]      cmd_rs1,
  output logic [31:0]      cmd_rs2,
  output logic             busy,
  output logic             done
);

  localparam logic [6:0] OPCODE = 7'b0001011;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RST    = 4'd1;
  localparam logic [3:0] S_WCFG   = 4'd2;
  localparam logic [3:0] S_WFAD   = 4'd3;
  localparam logic [3:0] S_WACC   = 4'd4;
  localparam logic [3:0] S_MATRIX = 4'd5;
  localparam logic [3:0] S_RACC   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
`ifdef HWPE_SEQ_RELU_EN
  localparam logic [3:0] S_RELU   = 4'd8;
  localparam logic [3:0] S_TILE0  = S_RELU;
`else
  localparam logic [3:0] S_TILE0  = S_RACC;
`endif

  localparam logic [2:0]       ROW_LAST = 3'(ROWS - 1);
  localparam logic [4:0]       PE_LAST  = 5'(PES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // FSM and loop counters; the counters describe the beat currently presented
  logic [3:0]       state_q;
  logic [1:0]       fad_q;
  logic [2:0]       row_q;
  logic [4:0]       pe_q;
  logic [CNT_W-1:0] k_q, w_q, h_q;

  // configuration latched at start
  logic [31:0]      cfg0_q, cfg1_q;
  logic [31:0]      base_q [8];
  logic [CNT_W-1:0] k_cnt_q, w_cnt_q, h_cnt_q;
  logic [15:0]      w_stride_q, h_stride_q;
  logic             skip_q;

  logic [3:0]       nxt_state;
  logic [1:0]       nxt_fad;
  logic [2:0]       nxt_row;
  logic [4:0]       nxt_pe;
  logic [CNT_W-1:0] nxt_k, nxt_w, nxt_h;
  logic [31:0]      pl_instr, pl_rs1, pl_rs2;

  logic [CNT_W-1:0] k_last, w_last, h_last;
  logic             any_zero, row_end, pe_end, final_tile, nxt_final, racc_en;
  logic             advance, nxt_beat;

  assign k_last     = k_cnt_q - CNT_ONE;
  assign w_last     = w_cnt_q - CNT_ONE;
  assign h_last     = h_cnt_q - CNT_ONE;
  assign any_zero   = (k_cnt_q == '0) || (w_cnt_q == '0) || (h_cnt_q == '0);
  assign row_end    = (row_q == ROW_LAST);
  assign pe_end     = (pe_q == PE_LAST);
  assign final_tile = (k_q == k_last) && (w_q == w_last) && (h_q == h_last);

  function automatic logic [31:0] mk_instr(input logic [6:0] f7,
                                           input logic [4:0] rs2f,
                                           input logic [4:0] rs1f,
                                           input logic [2:0] xbits,
                                           input logic [4:0] rd);
    return {f7, rs2f, rs1f, xbits, rd, OPCODE};
  endfunction

  // Next beat position. Only consulted when the FSM advances.
  always_comb begin
    nxt_state = state_q;
    nxt_fad   = fad_q;
    nxt_row   = row_q;
    nxt_pe    = pe_q;
    nxt_k     = k_q;
    nxt_w     = w_q;
    nxt_h     = h_q;
    case (state_q)
      S_IDLE: if (start) nxt_state = S_RST;
      S_RST:  nxt_state = S_WCFG;
      S_WCFG: begin
        nxt_state = S_WFAD;
        nxt_fad   = 2'd0;
      end
      S_WFAD: begin
        if (fad_q == 2'd3) begin
          nxt_row   = '0;
          nxt_pe    = '0;
          nxt_state = skip_q ? S_MATRIX : S_WACC;
        end else begin
          nxt_fad = fad_q + 2'd1;
        end
      end
      S_WACC: begin
        if (pe_end) begin
          nxt_pe = '0;
          if (row_end) begin
            nxt_row   = '0;
            nxt_state = S_MATRIX;
          end else begin
            nxt_row = row_q + 3'd1;
          end
        end else begin
          nxt_pe = pe_q + 5'd1;
        end
      end
      S_MATRIX: begin
        if (any_zero) begin
          nxt_state = S_DONE;
        end else begin
          nxt_k     = '0;
          nxt_w     = '0;
          nxt_h     = '0;
          nxt_row   = '0;
          nxt_pe    = '0;
          nxt_state = S_TILE0;
        end
      end
`ifdef HWPE_SEQ_RELU_EN
      S_RELU: begin
        if (row_end) begin
          nxt_row   = '0;
          nxt_pe    = '0;
          nxt_state = S_RACC;
        end else begin
          nxt_row = row_q + 3'd1;
        end
      end
`endif
      S_RACC: begin
        if (pe_end && row_end) begin
          nxt_row = '0;
          nxt_pe  = '0;
          if (final_tile) begin
            nxt_state = S_DONE;
          end else begin
            // H innermost, then W, then K
            nxt_state = S_TILE0;
            if (h_q != h_last) begin
              nxt_h = h_q + CNT_ONE;
            end else begin
              nxt_h = '0;
              if (w_q != w_last) begin
                nxt_w = w_q + CNT_ONE;
              end else begin
                nxt_w = '0;
                nxt_k = k_q + CNT_ONE;
              end
            end
          end
        end else if (pe_end) begin
          nxt_pe  = '0;
          nxt_row = row_q + 3'd1;
        end else begin
          nxt_pe = pe_q + 5'd1;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // The last RACC beat of every tile but the final one carries the racc_en
  // marker in the rs1 field.
  assign nxt_final = (nxt_k == k_last) && (nxt_w == w_last) && (nxt_h == h_last);
  assign racc_en   = (nxt_row == ROW_LAST) && (nxt_pe == PE_LAST) && !nxt_final;

  // Payload of the next beat, loaded into the output registers on advance
  always_comb begin
    pl_instr = '0;
    pl_rs1   = '0;
    pl_rs2   = '0;
    case (nxt_state)
      S_RST:  pl_instr = mk_instr(7'd64, 5'd0, 5'd0, 3'b000, 5'd0);
      S_WCFG: begin
        pl_instr = mk_instr(7'd2, 5'd0, 5'd0, 3'b011, 5'd0);
        pl_rs1   = cfg0_q;
        pl_rs2   = cfg1_q;
      end
      S_WFAD: begin
        pl_instr = mk_instr(7'd1, 5'd0, 5'd0, 3'b011, {2'b00, nxt_fad, 1'b0});
        pl_rs1   = base_q[{nxt_fad, 1'b0}];
        pl_rs2   = base_q[{nxt_fad, 1'b1}];
      end
      S_WACC:
        pl_instr = mk_instr(7'd8, nxt_pe, 5'd0, 3'b010, {2'b00, nxt_row});
      S_MATRIX: begin
        pl_instr = mk_instr(7'd4, 5'd0, 5'd0, 3'b011, 5'd0);
        pl_rs1   = {16'(w_cnt_q), 16'(h_cnt_q)};
        pl_rs2   = {w_stride_q, h_stride_q};
      end
`ifdef HWPE_SEQ_RELU_EN
      S_RELU:
        pl_instr = mk_instr(7'd32, {2'b00, nxt_row}, 5'd0, 3'b010, 5'd0);
`endif
      S_RACC:
        pl_instr = mk_instr(7'd16, nxt_pe,
                            {racc_en ? 2'b10 : 2'b00, nxt_row}, 3'b100, 5'd0);
      default: ;
    endcase
  end

  // DONE always falls through to IDLE; beat states move only on a transfer.
  assign advance  = ((state_q == S_IDLE) && start) || (state_q == S_DONE) ||
                    (cmd_valid && cmd_ready);
  assign nxt_beat = (nxt_state != S_IDLE) && (nxt_state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fad_q      <= '0;
      row_q      <= '0;
      pe_q       <= '0;
      k_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cfg0_q     <= '0;
      cfg1_q     <= '0;
      for (int n = 0; n < 8; n++) base_q[n] <= '0;
      k_cnt_q    <= '0;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      w_stride_q <= '0;
      h_stride_q <= '0;
      skip_q     <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_instr  <= '0;
      cmd_rs1    <= '0;
      cmd_rs2    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        cfg0_q     <= cfg0_i;
        cfg1_q     <= cfg1_i;
        for (int n = 0; n < 8; n++) base_q[n] <= base_addr_i[32*n +: 32];
        k_cnt_q    <= k_count_i;
        w_cnt_q    <= w_count_i;
        h_cnt_q    <= h_count_i;
        w_stride_q <= w_stride_i;
        h_stride_q <= h_stride_i;
        skip_q     <= skip_clr_i;
      end
      if (advance) begin
        state_q   <= nxt_state;
        fad_q     <= nxt_fad;
        row_q     <= nxt_row;
        pe_q      <= nxt_pe;
        k_q       <= nxt_k;
        w_q       <= nxt_w;
        h_q       <= nxt_h;
        cmd_valid <= nxt_beat;
        busy      <= nxt_beat;
        done      <= (nxt_state == S_DONE);
        cmd_instr <= pl_instr;
        cmd_rs1   <= pl_rs1;
        cmd_rs2   <= pl_rs2;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_instr_seq.sv
// Testbench for hwpe_instr_seq: directed layer configurations, beat stream
// compared against an independently built expected queue, plus protocol
// monitors for stall stability, busy/valid agreement and done timing.
module tb_hwpe_instr_seq;

`ifdef HWPE_SEQ_RELU_EN
  localparam int ROWS = 4;
  localparam int PES  = 8;
  localparam int R    = ROWS;
`else
  localparam int ROWS = 8;
  localparam int PES  = 16;
  localparam int R    = 0;
`endif
  localparam int CNT_W = 16;
  localparam int RP    = ROWS * PES;

  localparam logic [31:0] CFG0     = 32'h0010_0003;
  localparam logic [31:0] CFG1     = 32'hCAFE_0001;
  localparam logic [15:0] W_STRIDE = 16'h0040;
  localparam logic [15:0] H_STRIDE = 16'h0008;
  // plain racc at row ROWS-1 / pe PES-1 (0x20F3C00B for 8x16)
  localparam logic [31:0] LAST_PLAIN =
    {7'd16, 5'(PES - 1), 5'(ROWS - 1), 3'b100, 5'd0, 7'h0B};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [31:0]      cfg0_i = '0, cfg1_i = '0;
  logic [255:0]     base_addr_i = '0;
  logic [CNT_W-1:0] k_count_i = '0, w_count_i = '0, h_count_i = '0;
  logic [15:0]      w_stride_i = '0, h_stride_i = '0;
  logic             skip_clr_i = 1'b0;
  logic             cmd_valid, cmd_ready = 1'b0;
  logic [31:0]      cmd_instr, cmd_rs1, cmd_rs2;
  logic             busy, done;

  hwpe_instr_seq #(.ROWS(ROWS), .PES(PES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg0_i(cfg0_i), .cfg1_i(cfg1_i), .base_addr_i(base_addr_i),
    .k_count_i(k_count_i), .w_count_i(w_count_i), .h_count_i(h_count_i),
    .w_stride_i(w_stride_i), .h_stride_i(h_stride_i), .skip_clr_i(skip_clr_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .busy(busy), .done(done)
  );

  // ---------------- scoreboard state ----------------
  logic [95:0] exp_q[$];
  logic [95:0] got_q[$];
  logic [31:0] base_w [8];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt, done_bad, proto_err, stall_err;

  initial begin
    for (int n = 0; n < 8; n++) base_w[n] = 32'hA000_0000 + 32'(n) * 32'h0000_1111;
  end

  // Monitor: sampled on the falling edge, between active edges.
  initial begin
    bit prev_stall, prev_hs;
    logic [95:0] held;
    prev_stall = 0;
    prev_hs    = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_hs    = 0;
      end else begin
        if (prev_stall && (!cmd_valid || {cmd_instr, cmd_rs1, cmd_rs2} !== held))
          stall_err++;
        if (cmd_valid !== busy) proto_err++;
        if (done) begin
          done_cnt++;
          if (cmd_valid || !prev_hs) done_bad++;
        end
        prev_stall = cmd_valid && !cmd_ready;
        held       = {cmd_instr, cmd_rs1, cmd_rs2};
        prev_hs    = cmd_valid && cmd_ready;
        if (prev_hs) got_q.push_back({cmd_instr, cmd_rs1, cmd_rs2});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- expected-stream model ----------------
  function automatic logic [31:0] iw(input int f7, input int rs2f, input int rs1f,
                                     input int xb, input int rd);
    return {7'(f7), 5'(rs2f), 5'(rs1f), 3'(xb), 5'(rd), 7'h0B};
  endfunction

  task automatic build_exp(input int k, input int w, input int h, input bit skip);
    int total;
    exp_q.delete();
    exp_q.push_back({iw(64, 0, 0, 0, 0), 32'd0, 32'd0});
    exp_q.push_back({iw(2, 0, 0, 3, 0), CFG0, CFG1});
    for (int n = 0; n < 4; n++)
      exp_q.push_back({iw(1, 0, 0, 3, 2*n), base_w[2*n], base_w[2*n+1]});
    if (!skip)
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < PES; p++)
          exp_q.push_back({iw(8, p, 0, 2, r), 32'd0, 32'd0});
    exp_q.push_back({iw(4, 0, 0, 3, 0), {16'(w), 16'(h)}, {W_STRIDE, H_STRIDE}});
    total = k * w * h;
    for (int t = 0; t < total; t++) begin
      for (int id = 0; id < R; id++)
        exp_q.push_back({iw(32, id, 0, 2, 0), 32'd0, 32'd0});
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < PES; p++) begin
          int rs1f;
          rs1f = (r == ROWS-1 && p == PES-1 && t != total-1) ? (16 | r) : r;
          exp_q.push_back({iw(16, p, rs1f, 4, 0), 32'd0, 32'd0});
        end
    end
  endtask

  // index of first beat where got and expected differ, -1 if identical
  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int count_racc_en();
    int c = 0;
    foreach (got_q[i])
      if (got_q[i][95:89] == 7'd16 && got_q[i][83:82] == 2'b10) c++;
    return c;
  endfunction

  function automatic int count_wacc();
    int c = 0;
    foreach (got_q[i]) if (got_q[i][95:89] == 7'd8) c++;
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic run_seq(input int k, input int w, input int h, input bit skip,
                         input int stall_pct, output int cycles, output bit timeout);
    logic [255:0] b;
    got_q.delete();
    done_cnt = 0; done_bad = 0; proto_err = 0; stall_err = 0;
    for (int n = 0; n < 8; n++) b[32*n +: 32] = base_w[n];
    @(negedge clk);
    cfg0_i = CFG0; cfg1_i = CFG1; base_addr_i = b;
    k_count_i = 16'(k); w_count_i = 16'(w); h_count_i = 16'(h);
    w_stride_i = W_STRIDE; h_stride_i = H_STRIDE; skip_clr_i = skip;
    cmd_ready = ($urandom_range(0, 99) >= stall_pct);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs: the sequencer must run from its latched copy
    cfg0_i = ~CFG0; cfg1_i = ~CFG1; base_addr_i = ~b;
    k_count_i = 16'(k + 3); w_count_i = 16'(w + 1); h_count_i = 16'(h + 3);
    w_stride_i = ~W_STRIDE; h_stride_i = ~H_STRIDE; skip_clr_i = ~skip;
    cycles = 0;
    timeout = 1;
    for (int c = 0; c < 40000; c++) begin
      cmd_ready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      cycles++;
      if (done) begin
        timeout = 0;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", cmd_valid); end
    n_cmp++; if (cmd_instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h required 0", cmd_instr); end
    n_cmp++; if (cmd_rs1 !== 32'd0) begin n_bad++; $display("FAIL reset_rs1: got %h required 0", cmd_rs1); end
    n_cmp++; if (cmd_rs2 !== 32'd0) begin n_bad++; $display("FAIL reset_rs2: got %h required 0", cmd_rs2); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got valid=%b busy=%b required 0/0", cmd_valid, busy);
    end
  endtask

  task automatic test_default();
    int cyc, beats, d;
    bit to;
    logic [31:0] hand [7];
    hand = '{32'h8000000B, 32'h0400300B, 32'h0200300B, 32'h0200310B,
             32'h0200320B, 32'h0200330B, 32'h1000200B};
    beats = 7 + RP + 16 * (RP + R);   // 2183 for 8x16 without relu
    build_exp(2, 4, 2, 0);
    run_seq(2, 4, 2, 0, 0, cyc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL default_timeout: got no done required done"); end
    n_cmp++; if (got_q.size() != beats) begin n_bad++; $display("FAIL default_count: got %0d required %0d", got_q.size(), beats); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL default_stream: first diff at beat %0d required none", d); end
    for (int i = 0; i < 7; i++) begin
      logic [31:0] g;
      g = (i < got_q.size()) ? got_q[i][95:64] : 32'hxxxx_xxxx;
      n_cmp++; if (g !== hand[i]) begin n_bad++; $display("FAIL default_word%0d: got %h required %h", i, g, hand[i]); end
    end
    n_cmp++; if (got_q.size() < 3 || got_q[1][63:32] !== CFG0 || got_q[2][31:0] !== base_w[1]) begin
      n_bad++; $display("FAIL default_cfg_data: got size %0d, bad WCFG/WFAD data required cfg0=%h base1=%h", got_q.size(), CFG0, base_w[1]);
    end
    n_cmp++; if (count_racc_en() != 15) begin n_bad++; $display("FAIL default_racc_en: got %0d required 15", count_racc_en()); end
    n_cmp++; if (got_q.size() == 0 || got_q[$][95:64] !== LAST_PLAIN) begin
      n_bad++; $display("FAIL default_last_beat: got size %0d / wrong word required %h", got_q.size(), LAST_PLAIN);
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL default_done_pulses: got %0d required 1", done_cnt); end
    n_cmp++; if (done_bad != 0) begin n_bad++; $display("FAIL default_done_timing: got %0d bad required 0", done_bad); end
    n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL default_busy_valid: got %0d disagreements required 0", proto_err); end
    n_cmp++; if (cyc != beats + 1) begin n_bad++; $display("FAIL default_no_bubbles: got %0d cycles required %0d", cyc, beats + 1); end
  endtask

  task automatic test_stall();
    int cyc, d;
    bit to;
    build_exp(2, 4, 2, 0);
    run_seq(2, 4, 2, 0, 50, cyc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout: got no done required done"); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL stall_stream: first diff at beat %0d required none", d); end
    n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles required 0", stall_err); end
    n_cmp++; if (done_cnt != 1 || done_bad != 0) begin n_bad++; $display("FAIL stall_done: got %0d pulses %0d bad required 1/0", done_cnt, done_bad); end
    n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL stall_busy_valid: got %0d required 0", proto_err); end
  endtask

  task automatic test_skip_clr();
    int cyc, d;
    bit to;
    build_exp(1, 1, 1, 1);
    run_seq(1, 1, 1, 1, 0, cyc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL skip_timeout: got no done required done"); end
    n_cmp++; if (got_q.size() != 7 + RP + R) begin n_bad++; $display("FAIL skip_count: got %0d required %0d", got_q.size(), 7 + RP + R); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL skip_stream: first diff at beat %0d required none", d); end
    n_cmp++; if (count_wacc() != 0) begin n_bad++; $display("FAIL skip_no_wacc: got %0d required 0", count_wacc()); end
    n_cmp++; if (count_racc_en() != 0) begin n_bad++; $display("FAIL skip_no_racc_en: got %0d required 0", count_racc_en()); end
  endtask

  task automatic test_zero_count();
    int cyc, d;
    bit to;
    build_exp(2, 4, 0, 0);
    run_seq(2, 4, 0, 0, 0, cyc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL zero_timeout: got no done required done"); end
    n_cmp++; if (got_q.size() != 7 + RP) begin n_bad++; $display("FAIL zero_count: got %0d required %0d", got_q.size(), 7 + RP); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL zero_stream: first diff at beat %0d required none", d); end
    n_cmp++; if (got_q.size() == 0 || got_q[$] !== {32'h0800300B, 32'h0004_0000, W_STRIDE, H_STRIDE}) begin
      n_bad++; $display("FAIL zero_last_matrix: got size %0d / wrong beat required %h", got_q.size(), {32'h0800300B, 32'h0004_0000, W_STRIDE, H_STRIDE});
    end
    n_cmp++; if (done_cnt != 1 || done_bad != 0) begin n_bad++; $display("FAIL zero_done: got %0d pulses %0d bad required 1/0", done_cnt, done_bad); end
  endtask

  task automatic test_rst_mid();
    int cyc, d, leak;
    bit to;
    logic [255:0] b;
    for (int n = 0; n < 8; n++) b[32*n +: 32] = base_w[n];
    @(negedge clk);
    cfg0_i = CFG0; cfg1_i = CFG1; base_addr_i = b;
    k_count_i = 16'd2; w_count_i = 16'd4; h_count_i = 16'd2;
    skip_clr_i = 1'b0; cmd_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RP + 60) @(posedge clk);   // well inside the first tile's RACC beats
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cmd_valid, busy, done} !== 3'b000 || {cmd_instr, cmd_rs1, cmd_rs2} !== 96'd0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got v=%b b=%b d=%b instr=%h required all 0", cmd_valid, busy, done, cmd_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    leak = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_valid || busy || done) leak++;
    end
    n_cmp++; if (leak != 0) begin n_bad++; $display("FAIL rst_mid_no_resume: got %0d active cycles required 0", leak); end
    build_exp(1, 1, 1, 1);
    run_seq(1, 1, 1, 1, 0, cyc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rst_replay_timeout: got no done required done"); end
    n_cmp++; if (got_q.size() == 0 || got_q[0] !== {32'h8000000B, 64'd0}) begin
      n_bad++; $display("FAIL rst_replay_first: got size %0d / wrong first beat required RST 8000000b", got_q.size());
    end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rst_replay_stream: first diff at beat %0d required none", d); end
  endtask

`ifdef HWPE_SEQ_RELU_EN
  task automatic test_relu();
    int cyc, d;
    bit to;
    logic [31:0] relu_w [4];
    relu_w = '{32'h4000200B, 32'h4010200B, 32'h4020200B, 32'h4030200B};
    build_exp(1, 1, 1, 0);
    run_seq(1, 1, 1, 0, 0, cyc, to);
    n_cmp++; if (got_q.size() != 75) begin n_bad++; $display("FAIL relu_count: got %0d required 75", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] g;
      g = (39 + i < got_q.size()) ? got_q[39 + i][95:64] : 32'hxxxx_xxxx;
      n_cmp++; if (g !== relu_w[i]) begin n_bad++; $display("FAIL relu_word%0d: got %h required %h", i, g, relu_w[i]); end
    end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL relu_stream: first diff at beat %0d required none", d); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_default();
    test_stall();
    test_skip_clr();
    test_zero_count();
    test_rst_mid();
`ifdef HWPE_SEQ_RELU_EN
    test_relu();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwpe_instr_seq.md
# hwpe_instr_seq

Hardware instruction sequencer for the HWPE convolution accelerator. From a latched layer configuration it generates the complete custom-instruction stream for one convolution layer: reset, weight/layer config, four feature-address writes, accumulator clears, matrix setup, then the per-tile accumulator reads. It sits between the host command port and the HWPE command decoder. Each beat is a 96-bit command {instr, rs1 data, rs2 data} delivered over a valid/ready handshake.

## Interface
Parameters:
- ROWS, 8, accumulator rows (accreg ids); legal range 1..8
- PES, 16, PEs per row (pe ids); legal range 1..32
- CNT_W, 16, width of K/W/H tile counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- cfg0_i  in  32  {Conv_W_offset[15:0], Conv_CH_count[15:0]}
- cfg1_i  in  32  layer config word; forwarded unchanged
- base_addr_i  in  256  8 × 32-bit feature base addresses; entry n at [32n+31:32n]
- k_count_i, w_count_i, h_count_i  in  CNT_W each  tile loop counts
- w_stride_i, h_stride_i  in  16 each  matrix strides
- skip_clr_i  in  1  1 = omit the accumulator-clear phase
- cmd_valid  out  1  command beat valid
- cmd_ready  in  1  downstream accepts the beat
- cmd_instr  out  32  instruction word
- cmd_rs1  out  32  rs1 data
- cmd_rs2  out  32  rs2 data
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

## Operation
- Opcode is fixed at 7'b0001011. Instruction layout is {funct7, rs2, rs1, xd, xs1, xs2, rd, opcode}.
- States: IDLE → RST → WCFG → WFAD → WACC → MATRIX → [RELU] → RACC → DONE → IDLE.
- start in IDLE latches every *_i input. Inputs are ignored at all other times.
- RST: funct7=64, xd/xs1/xs2=000, rs1=rs2=0.
- WCFG: funct7=2, x-bits=011, rs1=cfg0, rs2=cfg1.
- WFAD: 4 beats, n=0..3. funct7=1, x-bits=011, rd=2n, rs1=base[2n], rs2=base[2n+1].
- WACC: ROWS×PES beats, row-outer, pe-inner. funct7=8, x-bits=010, rd=row, rs2 field=pe, data=0.
  - The whole phase is skipped when skip_clr is latched.
- MATRIX: funct7=4, x-bits=011, rs1={w_count[15:0], h_count[15:0]}, rs2={w_stride, h_stride}.
- Tile loop: K outer, then W, then H. Each tile runs [RELU], then ROWS×PES RACC beats (row-outer, pe-inner).
  - RACC beat: funct7=16, x-bits=100, rs1 field=row, rs2 field=pe, data=0.
  - Last beat of every tile except the final tile (row=ROWS-1, pe=PES-1) uses rs1 field {2'b10, row[2:0]}. This is the racc_en variant.
- If any of K/W/H count is 0, MATRIX goes directly to DONE.
- DONE: done=1 for one cycle, busy drops, state returns to IDLE.

## Timing
- Reset values: state=IDLE, cmd_valid=0, cmd_instr/rs1/rs2=0, busy=0, done=0, all counters 0.
- cmd_valid rises the cycle after start is accepted. busy rises in the same cycle.
- The beat advances only on cmd_valid & cmd_ready.
- While cmd_valid=1 and cmd_ready=0, the payload holds stable.
- cmd_valid never drops without a handshake, except on rst.
- With cmd_ready held at 1: one beat per cycle, no bubbles between phases or tiles.
- done asserts the cycle after the final handshake; cmd_valid=0 in that cycle.
- A new start is accepted no earlier than the cycle after done.
- rst mid-sequence aborts immediately to the reset values. No partial beat is emitted afterwards.
- Counters are registered outputs with no combinational path from cmd_ready to the payload.
- Beat count: 7 + (skip_clr ? 0 : ROWS×PES) + K×W×H×(ROWS×PES + R), where R=ROWS if HWPE_SEQ_RELU_EN is defined, else 0.

## Configuration
- HWPE_SEQ_RELU_EN defined: the RELU state is compiled in. Before each tile's RACC beats it emits ROWS beats, id=0..ROWS-1, with funct7=32, x-bits=010, rs2 field=id, data=0.
- Undefined: no RELU state or logic. Each tile is RACC beats only.

## Test plan
- Defaults, K=2, W=4, H=2, cmd_ready=1, RELU off → exactly 2183 beats. Words 0..6 decode to RST, WCFG, 4×WFAD (rd 0,2,4,6), then WACC row0/pe0. Tiles 1..15 each end with rs1 field 5'b10111. The last beat is a plain racc. done pulses once.
- Random cmd_ready stalls (about 50%) on the same config → identical beat sequence to the no-stall run. Payload stays constant across every stall cycle.
- skip_clr=1, K=1, W=1, H=1 → 7+128=135 beats. No funct7=8 beat appears. No racc_en beat appears.
- h_count=0 → 7+128=135 beats ending with MATRIX. done follows the next cycle.
- rst asserted mid-RACC → all outputs are 0 next cycle. A fresh start then replays from RST.
- HWPE_SEQ_RELU_EN defined, ROWS=4, PES=8, K=W=H=1 → the tile is 4 relu beats (ids 0..3) followed by 32 RACC beats.
